// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch (IF) and the data stage (DM).
// One transaction at a time: grant in IDLE, hold the command for LAT cycles, and return data with a valid pulse.
module mem_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  input  logic        dm_rdun,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  output logic [1:0]  mem_access_size,
  output logic        mem_RdUn,
  input  logic [31:0] mem_data_out,
  output logic        stall_if
);

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   lat_cnt_reg, lat_cnt_next;
  logic [SW-1:0]   starve_cnt_reg, starve_cnt_next;
  logic [31:0]     if_rdata_reg, dm_rdata_reg;
  logic [31:0]     mem_address_reg, mem_data_in_reg;
  logic [1:0]      mem_access_size_reg;
  logic            mem_w_enable_reg, mem_rdun_reg, wr_cmd_reg;
  logic            grant_if, grant_dm, last_cycle;

  always_comb begin
    state_next      = state_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    grant_if        = 1'b0;
    grant_dm        = 1'b0;
    if_valid        = 1'b0;
    dm_valid        = 1'b0;
    last_cycle      = (lat_cnt_reg == CW'(LAT - 1));

    case (state_reg)
      IDLE: begin
        lat_cnt_next = '0;
        // DM wins ties unless IF has already waited through STARVE_MAX DM grants
        if (dm_req && !(if_req && starve_cnt_reg == SW'(STARVE_MAX))) begin
          grant_dm   = 1'b1;
          state_next = BUSY_DM;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (last_cycle) begin
          state_next = IDLE;
          if_valid   = (state_reg == BUSY_IF);
          dm_valid   = (state_reg == BUSY_DM);
        end else begin
          lat_cnt_next = lat_cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (!if_req || grant_if) begin
      starve_cnt_next = '0;
    end else if (grant_dm && starve_cnt_reg != SW'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end

    // Reset silences handshakes in the same cycle so an aborted transfer never completes
    if (reset) begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if_valid = 1'b0;
      dm_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      lat_cnt_reg         <= '0;
      starve_cnt_reg      <= '0;
      if_rdata_reg        <= '0;
      dm_rdata_reg        <= '0;
      mem_address_reg     <= '0;
      mem_data_in_reg     <= '0;
      mem_access_size_reg <= '0;
      mem_w_enable_reg    <= 1'b0;
      mem_rdun_reg        <= 1'b0;
      wr_cmd_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      lat_cnt_reg      <= lat_cnt_next;
      starve_cnt_reg   <= starve_cnt_next;
      mem_w_enable_reg <= 1'b0;
      if (grant_dm) begin
        mem_address_reg     <= dm_addr;
        mem_data_in_reg     <= dm_wdata;
        mem_access_size_reg <= dm_size;
        mem_rdun_reg        <= dm_rdun;
        mem_w_enable_reg    <= dm_we;
        wr_cmd_reg          <= dm_we;
      end else if (grant_if) begin
        mem_address_reg     <= if_addr;
        mem_data_in_reg     <= '0;
        mem_access_size_reg <= SIZE_WORD;
        mem_rdun_reg        <= 1'b0;
        mem_w_enable_reg    <= 1'b0;
        wr_cmd_reg          <= 1'b0;
      end
      if (if_valid) if_rdata_reg <= mem_data_out;
      if (dm_valid && !wr_cmd_reg) dm_rdata_reg <= mem_data_out;
    end
  end

  // Read data is forwarded during the valid pulse and held afterwards
  assign if_rdata        = if_valid ? mem_data_out : if_rdata_reg;
  assign dm_rdata        = (dm_valid && !wr_cmd_reg) ? mem_data_out : dm_rdata_reg;
  assign if_gnt          = grant_if;
  assign dm_gnt          = grant_dm;
  assign mem_address     = mem_address_reg;
  assign mem_data_in     = mem_data_in_reg;
  assign mem_w_enable    = mem_w_enable_reg;
  assign mem_access_size = mem_access_size_reg;
  assign mem_RdUn        = mem_rdun_reg;
  assign stall_if        = if_req & ~((state_reg == BUSY_IF) & last_cycle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two configurations (LAT=1/STARVE_MAX=4, LAT=3/STARVE_MAX=2)
// checked cycle by cycle against a transaction-level model of grants, completions and memory contents.
module tb_mem_port_arbiter;

  localparam int N_CYC = 600;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input int i);
    return 32'h00A00093 + (i * 32'h9E3779B9);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int L  = (gi == 0) ? 1 : 3;
    localparam int SM = (gi == 0) ? 4 : 2;

    logic        reset, if_req, dm_req, dm_we, dm_rdun, fill;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [1:0]  dm_size;
    logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_w_enable, mem_RdUn, stall_if;
    logic [31:0] if_rdata, dm_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;
    logic [31:0] ram [64];

    mem_port_arbiter #(.LAT(L), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_size(dm_size), .dm_rdun(dm_rdun),
      .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_w_enable(mem_w_enable),
      .mem_access_size(mem_access_size), .mem_RdUn(mem_RdUn), .mem_data_out(mem_data_out),
      .stall_if(stall_if)
    );

    // Memory stand-in: combinational read, write on the clock edge
    assign mem_data_out = ram[mem_address[7:2]];
    always @(posedge clk) begin
      if (fill) begin
        for (int i = 0; i < 64; i++) ram[i] <= seed_word(i);
      end else if (mem_w_enable) begin
        ram[mem_address[7:2]] <= mem_data_in;
      end
    end

    initial begin : run
      logic [31:0] shadow [64];
      int          left, owner, starve, p_if, p_dm, p_drop, p_rst;
      logic [31:0] c_addr, c_wdata, txn_data, e_if_rd, e_dm_rd;
      logic [1:0]  c_size;
      logic        c_we, c_rdun, c_dm, busy, e_ig, e_dg, e_iv, e_dv, e_stall, seen_ig, seen_dg;
      string       pf;

      pf = $sformatf("c%0d_", gi);
      for (int i = 0; i < 64; i++) shadow[i] = seed_word(i);
      left = 0; owner = 0; starve = 0; txn_data = '0;
      c_addr = '0; c_wdata = '0; c_size = '0; c_we = 1'b0; c_rdun = 1'b0; c_dm = 1'b1;
      e_if_rd = '0; e_dm_rd = '0; seen_ig = 1'b0; seen_dg = 1'b0;
      reset = 1'b1; fill = 1'b1; if_req = 1'b0; dm_req = 1'b0; if_addr = '0;
      dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = '0; dm_rdun = 1'b0;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
        if (cyc > 0) begin
          @(posedge clk);
          #1;
          fill = 1'b0;
          // Phases: reset, IF only, both held (starvation), random mix with resets
          if (cyc < 3)        begin p_if = 0;   p_dm = 0;   p_drop = 0; p_rst = 0; end
          else if (cyc < 40)  begin p_if = 40;  p_dm = 0;   p_drop = 0; p_rst = 0; end
          else if (cyc < 120) begin p_if = 100; p_dm = 100; p_drop = 0; p_rst = 0; end
          else                begin p_if = 50;  p_dm = 50;  p_drop = 5; p_rst = 2; end
          reset = (cyc < 3) || ($urandom_range(0, 99) < p_rst);

          if (if_req && (seen_ig || $urandom_range(0, 99) < p_drop)) if_req = 1'b0;
          if (!if_req && $urandom_range(0, 99) < p_if) begin
            if_req  = 1'b1;
            if_addr = 32'h100 | ($urandom_range(0, 63) << 2);
          end
          if (dm_req && (seen_dg || $urandom_range(0, 99) < p_drop)) dm_req = 1'b0;
          if (!dm_req && $urandom_range(0, 99) < p_dm) begin
            dm_req   = 1'b1;
            dm_we    = ($urandom_range(0, 2) == 0);
            dm_addr  = 32'h2000 | ($urandom_range(0, 15) << 2);
            dm_wdata = $urandom;
            dm_size  = 2'($urandom_range(0, 2));
            dm_rdun  = 1'($urandom_range(0, 1));
          end
        end

        @(negedge clk);
        busy = (left > 0);
        e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
        if (!reset && busy && left == 1) begin
          if (owner == 1) e_iv = 1'b1;
          else            e_dv = 1'b1;
        end
        if (!reset && !busy) begin
          if (dm_req && !(if_req && starve == SM)) e_dg = 1'b1;
          else if (if_req)                         e_ig = 1'b1;
        end
        e_stall = if_req && !(busy && left == 1 && owner == 1);
        if (e_iv) e_if_rd = txn_data;
        if (e_dv && !c_we) e_dm_rd = txn_data;

        check({pf, "if_gnt"},    if_gnt,   e_ig);
        check({pf, "dm_gnt"},    dm_gnt,   e_dg);
        check({pf, "if_valid"},  if_valid, e_iv);
        check({pf, "dm_valid"},  dm_valid, e_dv);
        check({pf, "stall_if"},  stall_if, e_stall);
        check({pf, "if_rdata"},  if_rdata, e_if_rd);
        check({pf, "dm_rdata"},  dm_rdata, e_dm_rd);
        check({pf, "mem_addr"},  mem_address, c_addr);
        check({pf, "mem_we"},    mem_w_enable, busy && left == L && c_we);
        check({pf, "mem_size"},  mem_access_size, c_size);
        check({pf, "mem_rdun"},  mem_RdUn, c_rdun);
        check({pf, "starve"},    32'(dut.starve_cnt_reg), starve);
        if (c_dm) check({pf, "mem_wdata"}, mem_data_in, c_wdata);
        if (e_iv) $display("c%0d cyc=%0d IF  read  addr=%08h data=%08h", gi, cyc, c_addr, if_rdata);
        if (e_dv) $display("c%0d cyc=%0d DM  %s addr=%08h data=%08h", gi, cyc,
                           c_we ? "write" : "read ", c_addr, c_we ? c_wdata : dm_rdata);

        seen_ig = if_gnt;
        seen_dg = dm_gnt;
        if (reset) begin
          left = 0; owner = 0; starve = 0;
          c_addr = '0; c_wdata = '0; c_size = '0; c_we = 1'b0; c_rdun = 1'b0; c_dm = 1'b1;
          e_if_rd = '0; e_dm_rd = '0;
        end else begin
          if (busy) left--;
          if (e_dg) begin
            owner = 2; left = L; c_dm = 1'b1;
            c_addr = dm_addr; c_wdata = dm_wdata; c_we = dm_we; c_size = dm_size; c_rdun = dm_rdun;
            txn_data = shadow[dm_addr[7:2]];
            if (dm_we) shadow[dm_addr[7:2]] = dm_wdata;
          end else if (e_ig) begin
            owner = 1; left = L; c_dm = 1'b0;
            c_addr = if_addr; c_we = 1'b0; c_size = 2'b10; c_rdun = 1'b0;
            txn_data = shadow[if_addr[7:2]];
          end
          if (!if_req || e_ig)         starve = 0;
          else if (e_dg && starve < SM) starve++;
        end
      end
    end
  end

  initial begin
    repeat (N_CYC + 20) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
